// File: rtl/mmio_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmio_responder_pkg
// Purpose : Shared types and constants for the MMIO responder block:
//           bus address/data types, register offset encoding, responder
//           FSM state encoding, control/status bit positions and the
//           window-decode helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mmio_responder_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    // Register offsets within the 8-byte window (addr[2:0]).
    // Offsets 5..7 are unused and read as zero.
    typedef enum logic [2:0] {
        LED  = 3'd0,
        TLO  = 3'd1,
        THI  = 3'd2,
        CTRL = 3'd3,
        STAT = 3'd4
    } mmio_off_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mmio_state_t;

    localparam int MMIO_CTRL_EN_BIT   = 0;
    localparam int MMIO_STAT_WRAP_BIT = 0;

    // Window decode: compares address bits [15:3] only.
    function automatic logic in_window(input addr_t a, input addr_t base);
        return a[15:3] == base[15:3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module  : mmio_timer
// Purpose : Prescaled 16-bit up-counter. When enabled, the prescaler counts
//           0..PRESCALE-1 and the counter increments on its terminal count.
//           Byte loads from the bus take priority over the increment and
//           restart the prescaler.
// Ports   : clk        in  system clock
//           rst_n      in  synchronous active-low reset
//           en         in  count enable
//           lo_we      in  load count[7:0] from wdata
//           hi_we      in  load count[15:8] from wdata
//           wdata      in  load data
//           count      out current counter value
//           wrap_pulse out strobe: counter goes FFFF->0000 on this edge
// Revision: 1.0 - initial release
// ============================================================================
module mmio_timer
    import mmio_responder_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        lo_we,
    input  logic        hi_we,
    input  data_t       wdata,
    output logic [15:0] count,
    output logic        wrap_pulse
);

    logic [15:0] presc;
    logic        terminal;
    logic        load;

    assign load     = lo_we | hi_we;
    assign terminal = (presc == PRESCALE - 16'd1);

    // A bus load on the same edge suppresses the increment, so no wrap either.
    assign wrap_pulse = en && terminal && !load && (count == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= 16'd0;
            count <= 16'd0;
        end else if (load) begin
            presc <= 16'd0;
            if (lo_we) count[7:0]  <= wdata;
            if (hi_we) count[15:8] <= wdata;
        end else if (en) begin
            if (terminal) begin
                presc <= 16'd0;
                count <= count + 16'd1;
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module  : mmio_responder
// Purpose : Bus responder for the CPU MMIO window (8 bytes at BASE_ADDR).
//           Answers byte accesses with a one-cycle ack, owns the LED
//           register, timer control, timer hi-byte read shadow and the
//           sticky wrap flag. The prescaled timer lives in mmio_timer.
// Config  : MMIO_WAIT_STATE_EN - when defined, one WAIT cycle is inserted
//           between IDLE and ACCESS (ack two cycles after the request edge).
// Ports   : clk    in  system clock
//           rst_n  in  synchronous active-low reset
//           req    in  access request, held with addr/mw/wdata until ack
//           mw     in  1 = write, 0 = read
//           addr   in  byte address
//           wdata  in  write data
//           hit    out addr decodes inside the window (combinational)
//           ack    out one-cycle completion pulse
//           rdata  out read data, valid with ack, zero otherwise
//           led    out LED register
// Revision: 1.0 - initial release
// ============================================================================
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter addr_t       BASE_ADDR = 16'hD000,
    parameter logic [15:0] PRESCALE  = 16'd1000
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req,
    input  logic  mw,
    input  addr_t addr,
    input  data_t wdata,
    output logic  hit,
    output logic  ack,
    output data_t rdata,
    output data_t led
);

    mmio_state_t state;
    mmio_off_t   off;
    logic        ctrl_en;
    logic        wrap_flag;
    data_t       hi_shadow;
    data_t       rd_val;
    logic        start;
    logic        do_wr;
    logic        do_rd;
    logic        lo_we;
    logic        hi_we;
    logic [15:0] count;
    logic        wrap_pulse;

    assign hit = in_window(addr, BASE_ADDR);
    assign off = mmio_off_t'(addr[2:0]);

    // start marks the edge on which the register operation takes effect;
    // ack and rdata are registered on that same edge, so they appear in the
    // following (ACCESS) cycle.
`ifdef MMIO_WAIT_STATE_EN
    assign start = (state == WAIT);
`else
    assign start = (state == IDLE) && req && hit;
`endif

    assign do_wr = start && mw;
    assign do_rd = start && !mw;
    assign lo_we = do_wr && (off == TLO);
    assign hi_we = do_wr && (off == THI);

    always_comb begin
        rd_val = '0;
        case (off)
            LED:  rd_val = led;
            TLO:  rd_val = count[7:0];
            THI:  rd_val = hi_shadow;
            CTRL: rd_val[MMIO_CTRL_EN_BIT]   = ctrl_en;
            STAT: rd_val[MMIO_STAT_WRAP_BIT] = wrap_flag;
            default: rd_val = '0;
        endcase
    end

    mmio_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (ctrl_en),
        .lo_we      (lo_we),
        .hi_we      (hi_we),
        .wdata      (wdata),
        .count      (count),
        .wrap_pulse (wrap_pulse)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= 1'b0;
            rdata     <= '0;
            led       <= '0;
            ctrl_en   <= 1'b0;
            wrap_flag <= 1'b0;
            hi_shadow <= '0;
        end else begin
            ack   <= start;
            rdata <= do_rd ? rd_val : '0;

            case (state)
                IDLE: begin
                    if (req && hit) begin
`ifdef MMIO_WAIT_STATE_EN
                        state <= WAIT;
`else
                        state <= ACCESS;
`endif
                    end
                end
                WAIT:    state <= ACCESS;
                ACCESS:  state <= DONE;
                // Hold here until the initiator drops req so a held
                // request is never acknowledged twice.
                DONE:    if (!req) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (do_wr && (off == LED))  led     <= wdata;
            if (do_wr && (off == CTRL)) ctrl_en <= wdata[MMIO_CTRL_EN_BIT];

            // Shadow captures the same pre-increment count that TLO returns.
            if (do_rd && (off == TLO)) hi_shadow <= count[15:8];

            // A wrap on the same edge as a STAT read-clear leaves the flag set.
            if (wrap_pulse)
                wrap_flag <= 1'b1;
            else if (do_rd && (off == STAT))
                wrap_flag <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mmio_responder
// Purpose : Self-checking bench for mmio_responder. Expected read data is
//           queued at each access and compared by an ack-driven monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mmio_responder;

    localparam logic [15:0] BASE = 16'hD000;
    localparam int          P    = 2;
`ifdef MMIO_WAIT_STATE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        mw    = 1'b0;
    logic [15:0] addr  = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        hit;
    logic        ack;
    logic [7:0]  rdata;
    logic [7:0]  led;

    mmio_responder #(
        .BASE_ADDR (BASE),
        .PRESCALE  (16'(P))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .mw    (mw),
        .addr  (addr),
        .wdata (wdata),
        .hit   (hit),
        .ack   (ack),
        .rdata (rdata),
        .led   (led)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int acks_seen = 0;
    int acks_exp  = 0;
    logic [7:0] exp_q[$];

    // Reference model: timer value = base + (enabled cycles since load)/P.
    logic [7:0] m_led;
    logic [7:0] m_shadow;
    bit         m_en;
    bit         m_wrap;
    int         m_base;
    int         m_n;

    function automatic logic [15:0] m_timer();
        return 16'((m_base + m_n / P) & 32'hFFFF);
    endfunction

    // Does the k-th edge from now carry the timer across a 2^16 boundary?
    function automatic bit wraps_after(input int k);
        return m_en && (((m_base + (m_n + k) / P) >> 16) != ((m_base + (m_n + k - 1) / P) >> 16));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_led = 8'h00; m_shadow = 8'h00; m_en = 0; m_wrap = 0; m_base = 0; m_n = 0;
    endtask

    task automatic tick();
        int o;
        if (m_en) begin
            o = (m_base + m_n / P) >> 16;
            m_n++;
            if (((m_base + m_n / P) >> 16) != o) m_wrap = 1;
        end
    endtask

    task automatic model_access();
        logic [7:0]  rd;
        logic [15:0] t;
        rd = 8'h00;
        t  = m_timer();
        acks_exp++;
        if (!mw) begin
            case (addr[2:0])
                3'd0: rd = m_led;
                3'd1: begin rd = t[7:0]; m_shadow = t[15:8]; end
                3'd2: rd = m_shadow;
                3'd3: rd = {7'b0, m_en};
                3'd4: begin rd = {7'b0, m_wrap}; m_wrap = 0; end
                default: rd = 8'h00;
            endcase
        end
        exp_q.push_back(rd);
        if (mw && addr[2:0] == 3'd1) begin
            m_base = {16'h0, t[15:8], wdata}; m_n = 0;
        end else if (mw && addr[2:0] == 3'd2) begin
            m_base = {16'h0, wdata, t[7:0]}; m_n = 0;
        end else begin
            tick();
        end
        if (mw && addr[2:0] == 3'd0) m_led = wdata;
        if (mw && addr[2:0] == 3'd3) m_en  = wdata[0];
    endtask

    // One clock edge; the model follows the DUT on the same edge.
    task automatic step(input bit acc);
        @(posedge clk);
        if (!rst_n)   model_reset();
        else if (acc) model_access();
        else          tick();
        #1;
    endtask

    task automatic access(input bit w, input logic [15:0] a, input logic [7:0] d, input int hold);
        logic [15:0] b;
        bit in_win;
        b = BASE;
        in_win = (a[15:3] == b[15:3]);
        req = 1'b1; mw = w; addr = a; wdata = d;
        #1;
        check("hit", hit, in_win);
        if (in_win) begin
            for (int i = 1; i < LAT; i++) step(0);
            step(1);
        end
        for (int i = 0; i < hold; i++) step(0);
        req = 1'b0;
        step(0);
        step(0);
        check("ack_count", acks_seen, acks_exp);
        check("led", led, m_led);
    endtask

    // Monitor: every ack pops one expected read value.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            acks_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack (t=%0t)", $time);
            end else begin
                check("rdata", rdata, exp_q.pop_front());
            end
        end else begin
            check("rdata_zero_no_ack", rdata, 8'h00);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        model_reset();

        // Reset held with a pending LED write: no ack, LED stays clear.
        req = 1'b1; mw = 1'b1; addr = BASE; wdata = 8'h5A;
        for (int i = 0; i < 5; i++) step(0);
        check("reset_led", led, 8'h00);
        check("reset_ack", acks_seen, 0);
        rst_n = 1'b1; req = 1'b0;
        step(0);
        check("post_reset_led", led, 8'h00);
        check("post_reset_rdata", rdata, 8'h00);

        // LED write, held request gives a single ack.
        access(1, 16'hD000, 8'hA5, 5);
        check("led_a5", led, 8'hA5);
        access(0, 16'hD000, 8'h00, 0);
        access(0, 16'hD005, 8'h00, 1);
        access(1, 16'hD006, 8'h77, 0);
        access(0, 16'hC000, 8'h00, 10);

        // Timer near wrap, STAT read and clear, hi-shadow behaviour.
        access(1, 16'hD002, 8'hFF, 0);
        access(1, 16'hD001, 8'hFE, 0);
        access(1, 16'hD003, 8'h01, 0);
        for (int i = 0; i < 4; i++) step(0);
        access(0, 16'hD004, 8'h00, 0);
        access(0, 16'hD004, 8'h00, 0);
        access(0, 16'hD001, 8'h00, 0);
        for (int i = 0; i < 12; i++) step(0);
        access(0, 16'hD002, 8'h00, 0);
        access(0, 16'hD001, 8'h00, 0);
        access(0, 16'hD003, 8'h00, 0);

        // Wrap and STAT read-clear on the same edge: read old, flag stays set.
        access(1, 16'hD003, 8'h00, 0);
        access(1, 16'hD002, 8'hFF, 0);
        access(1, 16'hD001, 8'hF0, 0);
        access(0, 16'hD004, 8'h00, 0);
        access(1, 16'hD003, 8'h01, 0);
        guard = 0;
        while (!wraps_after(LAT) && guard < 1000) begin
            step(0);
            guard++;
        end
        check("wrap_align_guard", guard < 1000, 1'b1);
        access(0, 16'hD004, 8'h00, 0);
        access(0, 16'hD004, 8'h00, 0);
        access(0, 16'hD004, 8'h00, 0);

        // Reset on the edge that would perform an LED write of 3C.
        req = 1'b1; mw = 1'b1; addr = BASE; wdata = 8'h3C;
        for (int i = 1; i < LAT; i++) step(0);
        rst_n = 1'b0;
        step(0);
        rst_n = 1'b1; req = 1'b0;
        step(0);
        step(0);
        check("rst_mid_ack", acks_seen, acks_exp);
        check("rst_mid_led", led, 8'h00);
        access(1, 16'hD000, 8'h3C, 0);
        check("reissue_led", led, 8'h3C);

        // Randomized traffic, mostly inside the window.
        for (int t = 0; t < 80; t++) begin
            logic [15:0] a;
            if ($urandom_range(0, 9) < 8) a = BASE + 16'($urandom_range(0, 7));
            else                          a = 16'($urandom);
            access(1'($urandom_range(0, 1)), a, 8'($urandom), int'($urandom_range(0, 3)));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) step(0);
        end

        step(0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
